// File: rtl/pe_arr_pkg.sv
// pe_arr_pkg: definitions shared by PE_ARR, its feeders and the result drain.
// Holds the accumulator width, the default array geometry, the drain state
// enum and a helper that sizes an index for a given element count.
package pe_arr_pkg;

    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned ROWS_DEF  = 4;
    localparam int unsigned COLS_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    // Index width for n elements; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_arr_drain_if.sv
// pe_arr_drain_if: valid/ready result stream leaving the PE_ARR drain.
// Signals: o_data (word), o_valid, o_ready (from sink), o_idx (flat index k),
// o_last (k == N-1). master = drain side, slave = host/writeback side.
interface pe_arr_drain_if
    import pe_arr_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned IDX_W = idx_w(ROWS_DEF * COLS_DEF)
);
    logic [ACC_W-1:0] o_data;
    logic             o_valid;
    logic             o_ready;
    logic [IDX_W-1:0] o_idx;
    logic             o_last;

    modport master (
        output o_data,
        output o_valid,
        output o_idx,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_idx,
        input  o_last,
        output o_ready
    );
endinterface

// File: rtl/pe_arr_drain.sv
// pe_arr_drain: snapshots the PE_ARR result bus on an accepted start and
// streams the ROWS*COLS words out in row-major order, one per cycle.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   start      - one-cycle request to snapshot outs and drain
//   outs       - flat result bus [0:ACC_W*N-1], element k MSB at bit ACC_W*k
//   drn        - result stream (o_data/o_valid/o_ready/o_idx/o_last)
//   busy       - drain in progress
//   dropped    - one-cycle pulse after an ignored start
module pe_arr_drain
    import pe_arr_pkg::*;
#(
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [0:ACC_W*ROWS*COLS-1]  outs,
    pe_arr_drain_if.master              drn,
    output logic                        busy,
    output logic                        dropped
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = idx_w(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_e     state_q, state_d;
    logic [ACC_W-1:0] snap_q [N];
    logic [ACC_W-1:0] snap_d [N];
    logic [ACC_W-1:0] outs_w [N];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             dropped_q, dropped_d;
    logic             capture;

    // Split the ascending bus; the lowest-numbered bit of each slice is its MSB.
    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign outs_w[k] = outs[ACC_W*k +: ACC_W];
    end

    // Next state, snapshot and next output values.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        dropped_d = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // o_valid is always high in SEND, so o_ready alone is the handshake.
                if (drn.o_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (start) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (start && !capture) begin
                    dropped_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            snap_d = outs_w;
            idx_d  = '0;
        end
        // Output word is preloaded so o_data comes straight from a flop.
        data_d = (state_d == SEND) ? snap_d[idx_d] : '0;
        last_d = (state_d == SEND) && (idx_d == LAST_IDX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            dropped_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            last_q    <= last_d;
            dropped_q <= dropped_d;
            snap_q    <= snap_d;
        end
    end

    assign drn.o_valid = (state_q == SEND);
    assign drn.o_data  = data_q;
    assign drn.o_idx   = idx_q;
    assign drn.o_last  = last_q;
    assign busy        = (state_q == SEND);
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_pe_arr_drain.sv
// tb_pe_arr_drain: self-checking bench for pe_arr_drain. A cycle table covers
// the basic drain with an ignored start; hand sequences cover reset, snapshot
// isolation with backpressure, back-to-back restart and mid-drain reset; a
// random phase is checked against a queue-based model of the stream.
module tb_pe_arr_drain;
    import pe_arr_pkg::*;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned W    = 32;
    localparam int unsigned IW   = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [0:W*N-1]   outs;
    logic             busy;
    logic             dropped;

    pe_arr_drain_if #(.ACC_W(W), .IDX_W(IW)) bus ();

    pe_arr_drain #(.ROWS(ROWS), .COLS(COLS), .ACC_W(W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .outs    (outs),
        .drn     (bus),
        .busy    (busy),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Words currently presented on outs (element k).
    logic [W-1:0] cur_vals [N];

    // Reference model: queue of words still owed to the sink.
    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } word_t;
    word_t q[$];
    bit    m_drop;

    task automatic apply_outs();
        for (int k = 0; k < N; k++)
            for (int b = 0; b < W; b++)
                outs[W*k + b] = cur_vals[k][W-1-b];
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit s, input bit r);
        word_t w;
        if (q.size() > 0 && r) void'(q.pop_front());
        m_drop = s && (q.size() != 0);
        if (s && q.size() == 0) begin
            for (int k = 0; k < N; k++) begin
                w.idx  = k;
                w.data = cur_vals[k];
                q.push_back(w);
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drop = 1'b0;
    endtask

    task automatic check_model(input string tag);
        bit ev;
        ev = (q.size() > 0);
        chk({tag, ".valid"},   64'(bus.o_valid), 64'(ev));
        chk({tag, ".busy"},    64'(busy),        64'(ev));
        chk({tag, ".dropped"}, 64'(dropped),     64'(m_drop));
        if (ev) begin
            chk({tag, ".idx"},  64'(bus.o_idx),  64'(q[0].idx));
            chk({tag, ".data"}, 64'(bus.o_data), 64'(q[0].data));
            chk({tag, ".last"}, 64'(bus.o_last), 64'(q[0].idx == N - 1));
        end else begin
            chk({tag, ".last"}, 64'(bus.o_last), 64'd0);
        end
    endtask

    // Check at the falling edge, then drive the inputs for the next rising edge.
    task automatic step(input bit s, input bit r, input string tag);
        @(negedge clk);
        check_model(tag);
        start       = s;
        bus.o_ready = r;
        apply_outs();
        model_step(s, r);
    endtask

    typedef struct {
        bit           start;
        bit           ready;
        bit           ev;
        int           eidx;
        logic [W-1:0] edata;
        bit           elast;
        bit           edrop;
    } vec_t;
    vec_t tbl [19];

    initial begin
        // Expected cycle-by-cycle view of a basic drain with a start at idx 5.
        tbl[0] = '{start: 1'b1, ready: 1'b1, ev: 1'b0, eidx: 0, edata: '0, elast: 1'b0, edrop: 1'b0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{start: (i == 6), ready: 1'b1, ev: 1'b1, eidx: i - 1,
                       edata: 32'h1000_0000 + 32'(i - 1), elast: (i == 16), edrop: (i == 7)};
        tbl[17] = '{start: 1'b0, ready: 1'b1, ev: 1'b0, eidx: 0, edata: '0, elast: 1'b0, edrop: 1'b0};
        tbl[18] = tbl[17];

        rstn        = 1'b0;
        start       = 1'b0;
        bus.o_ready = 1'b0;
        for (int k = 0; k < N; k++) cur_vals[k] = '0;
        apply_outs();
        model_reset();

        // Reset held for three cycles, then idle.
        repeat (3) @(negedge clk);
        chk("rst.valid", 64'(bus.o_valid), 64'd0);
        chk("rst.busy",  64'(busy),        64'd0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, "idle");
            chk("idle.data", 64'(bus.o_data), 64'd0);
            chk("idle.idx",  64'(bus.o_idx),  64'd0);
        end

        // Table-driven basic drain.
        for (int k = 0; k < N; k++) cur_vals[k] = 32'h1000_0000 + 32'(k);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk("tbl.valid",   64'(bus.o_valid), 64'(tbl[i].ev));
            chk("tbl.busy",    64'(busy),        64'(tbl[i].ev));
            chk("tbl.dropped", 64'(dropped),     64'(tbl[i].edrop));
            chk("tbl.last",    64'(bus.o_last),  64'(tbl[i].elast));
            if (tbl[i].ev) begin
                chk("tbl.idx",  64'(bus.o_idx),  64'(tbl[i].eidx));
                chk("tbl.data", 64'(bus.o_data), 64'(tbl[i].edata));
            end
            start       = tbl[i].start;
            bus.o_ready = tbl[i].ready;
            apply_outs();
            model_step(tbl[i].start, tbl[i].ready);
        end

        // Snapshot isolation under backpressure pattern 1,0,0,1.
        for (int k = 0; k < N; k++) cur_vals[k] = 32'h2000_0000 + 32'(k);
        step(1'b1, 1'b1, "iso");
        for (int k = 0; k < N; k++) cur_vals[k] = 32'hFFFF_FFFF;
        for (int i = 0; i < 36; i++) step((i % 4) == 0 || (i % 4) == 3, 1'b0, "iso")
            ;
        for (int i = 0; i < 36; i++) step(1'b0, (i % 4) == 0 || (i % 4) == 3, "iso");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "iso");

        // Back-to-back: start coincides with the idx-15 handshake.
        for (int k = 0; k < N; k++) cur_vals[k] = 32'h3000_0000 + 32'(k);
        step(1'b1, 1'b1, "b2b");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "b2b");
        for (int k = 0; k < N; k++) cur_vals[k] = 32'(k * 2);
        step(1'b1, 1'b1, "b2b");
        step(1'b0, 1'b1, "b2b");
        chk("b2b.idx0",  64'(bus.o_idx),  64'd0);
        chk("b2b.data0", 64'(bus.o_data), 64'd0);
        chk("b2b.busy",  64'(busy),       64'd1);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, "b2b");

        // Asynchronous reset in the middle of a drain.
        for (int k = 0; k < N; k++) cur_vals[k] = 32'h4000_0000 + 32'(k);
        step(1'b1, 1'b1, "mrst");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "mrst");
        @(posedge clk);
        #1;
        chk("mrst.idx7", 64'(bus.o_idx), 64'd7);
        #1;
        rstn = 1'b0;
        #1;
        chk("mrst.valid", 64'(bus.o_valid), 64'd0);
        chk("mrst.busy",  64'(busy),        64'd0);
        chk("mrst.idx",   64'(bus.o_idx),   64'd0);
        model_reset();
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b0;
        for (int k = 0; k < N; k++) cur_vals[k] = 32'h5000_0000 + 32'(k);
        step(1'b0, 1'b0, "mrst");
        step(1'b1, 1'b1, "mrst");
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, "mrst");

        // Random starts, backpressure and bus changes against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0)
                for (int k = 0; k < N; k++) cur_vals[k] = $urandom;
            step($urandom_range(7) == 0, $urandom_range(3) != 0, "rnd");
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, "rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
